// File: rtl/leak_reversal_engine.sv
// leak_reversal_engine: time-multiplexed, two-stage pipelined leak/reversal stage.
// Each beat carries a channel index, a signed leak and a signed membrane potential.
// The per-channel mode register selects how the leak is applied.
// The result is saturated to POT_W bits.
// Optional build macro LEAK_SAT_CNT_EN adds the sat_cnt output and the sat_cnt_clr input.
// sat_cnt is a saturating 16-bit count of clamped beats accepted downstream.
module leak_reversal_engine #(
    parameter int LEAK_W = 8,
    parameter int POT_W  = 16,
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [1:0]               cfg_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [LEAK_W-1:0] in_leak,
    input  logic signed [POT_W-1:0]  in_vm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [POT_W-1:0]  out_vm,
    output logic                     out_sat
`ifdef LEAK_SAT_CNT_EN
    ,
    input  logic                     sat_cnt_clr,
    output logic [15:0]              sat_cnt
`endif
);

    // Mode encodings
    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_INVERT = 2'b01;
    localparam logic [1:0] MODE_ZERO   = 2'b10;

    // Effective leak from mode, sign-extended leak and the incoming potential.
    // Negating the most negative leak is safe because POT_W > LEAK_W.
    function automatic logic signed [POT_W-1:0] eff_leak(
        input logic [1:0]              mode,
        input logic signed [POT_W-1:0] l,
        input logic signed [POT_W-1:0] vm
    );
        logic signed [POT_W-1:0] le;
        case (mode)
            MODE_NORMAL: le = l;
            MODE_INVERT: le = -l;
            MODE_ZERO:   le = '0;
            default: begin
                if (vm[POT_W-1])   le = -l;
                else if (vm == '0) le = '0;
                else               le = l;
            end
        endcase
        return le;
    endfunction

    // True when the one-bit-wider sum cannot be represented in POT_W bits.
    function automatic logic sat_hit(input logic signed [POT_W:0] s);
        return s[POT_W] ^ s[POT_W-1];
    endfunction

    // Clamp the one-bit-wider sum into the POT_W two's complement range.
    function automatic logic signed [POT_W-1:0] sat_pot(input logic signed [POT_W:0] s);
        logic signed [POT_W-1:0] r;
        if (sat_hit(s))
            r = s[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
        else
            r = s[POT_W-1:0];
        return r;
    endfunction

    logic [1:0]              mode_reg [NUM_CH];
    logic [1:0]              mode_sel;
    logic signed [POT_W-1:0] leak_ext;
    logic                    adv;

    logic                    vld_p1;
    logic [CH_W-1:0]         ch_p1;
    logic signed [POT_W-1:0] vm_p1;
    logic signed [POT_W-1:0] le_p1;
    logic signed [POT_W:0]   sum_p1;

    logic                    vld_p2;
    logic [CH_W-1:0]         ch_p2;
    logic signed [POT_W-1:0] vm_p2;
    logic                    sat_p2;

    // Both stages advance together whenever the output slot is free or being taken.
    assign adv      = !vld_p2 || out_ready;
    assign in_ready = adv;
    assign leak_ext = {{(POT_W-LEAK_W){in_leak[LEAK_W-1]}}, in_leak};

    // Mode lookup for the incoming beat.
    // Out-of-range channels fall back to normal mode.
    always_comb begin
        mode_sel = MODE_NORMAL;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CH_W'(i)) mode_sel = mode_reg[i];
        end
    end

    // Mode register file.
    // Out-of-range writes match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) mode_reg[i] <= 2'b00;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_ch == CH_W'(i)) mode_reg[i] <= cfg_mode;
            end
        end
    end

    // ---- stage 1: capture channel, potential and effective leak ----
    // Stage 1 valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   vld_p1 <= 1'b0;
        else if (adv) vld_p1 <= in_valid;
    end

    // Stage 1 data.
    // The mode read here is the pre-write value on a same-edge config write.
    always_ff @(posedge clk) begin
        if (adv) begin
            ch_p1 <= in_ch;
            vm_p1 <= in_vm;
            le_p1 <= eff_leak(mode_sel, leak_ext, in_vm);
        end
    end

    assign sum_p1 = {vm_p1[POT_W-1], vm_p1} + {le_p1[POT_W-1], le_p1};

    // ---- stage 2: saturating add, registered output ----
    // Output register.
    // It holds while downstream stalls, which keeps the presented beat stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            ch_p2  <= '0;
            vm_p2  <= '0;
            sat_p2 <= 1'b0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            ch_p2  <= ch_p1;
            vm_p2  <= sat_pot(sum_p1);
            sat_p2 <= sat_hit(sum_p1);
        end
    end

    assign out_valid = vld_p2;
    assign out_ch    = ch_p2;
    assign out_vm    = vm_p2;
    assign out_sat   = sat_p2;

`ifdef LEAK_SAT_CNT_EN
    // Count clamped beats taken by downstream.
    // Clear wins, and the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (sat_cnt_clr)
            sat_cnt <= '0;
        else if (vld_p2 && out_ready && sat_p2 && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/leak_reversal_engine.md
Name: leak_reversal_engine

Overview:
- Parametrised, pipelined successor to the single-channel combinational leak/reversal stage.
- Applies a per-channel, mode-selected leak to a streamed membrane potential and outputs the saturated updated potential.
- Sits between the neuron state SRAM read port and the integrate/threshold stage.
- Time-multiplexes NUM_CH neurons over one datapath, with valid/ready flow control and per-channel mode registers.

Parameters:
- LEAK_W, 8: signed leak width (two's complement).
- POT_W, 16: signed membrane potential width; must be at least LEAK_W+1.
- NUM_CH, 4: number of channels (neurons) sharing the datapath; must be at least 2.
- CH_W, $clog2(NUM_CH): channel index width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  mode register write strobe.
- cfg_ch  in  CH_W  channel index of the mode register to write.
- cfg_mode  in  2  mode value to write.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept an input beat.
- in_ch  in  CH_W  channel of the input beat.
- in_leak  in  LEAK_W  signed leak value.
- in_vm  in  POT_W  signed membrane potential.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_ch  out  CH_W  channel of the output beat.
- out_vm  out  POT_W  updated, saturated potential.
- out_sat  out  1  this output beat was clamped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all mode registers go to 2'b00;
  - both pipeline valid bits, out_valid, out_sat, out_ch and out_vm go to 0.
  - in_ready is combinational and equals 1 while in reset.
  - Reset asserted mid-stream discards all in-flight beats with no output.
- Mode registers: NUM_CH x 2 bits, written when cfg_we=1 at the clock edge.
- Mode decode, with L = in_leak sign-extended to POT_W:
  - 00 normal: effective leak Le = L.
  - 01 invert: Le = -L. For L = -2^(LEAK_W-1), Le = +2^(LEAK_W-1); this is representable in POT_W.
  - 10 zero: Le = 0. The beat still passes through with out_vm = in_vm and out_sat = 0.
  - 11 reversal: Le = sgn(in_vm)*L, so the leak drives toward or away from zero by the sign of in_vm. If in_vm = 0 then Le = 0.
- Pipeline, two register stages:
  - S1 captures ch, vm, Le, with the mode looked up from mode_reg[in_ch] at the accept edge.
  - S2 computes sum = vm + Le at POT_W+1 bits, clamps to [-2^(POT_W-1), 2^(POT_W-1)-1], and sets out_sat when clamping occurred.
- Flow control:
  - adv = !out_valid || out_ready.
  - in_ready = adv.
  - On adv, S1 loads the input and S2 loads S1. When adv=0 both stages hold.
  - Latency: an accepted beat appears on out_valid exactly 2 cycles later when out_ready stays high.
  - Sustained throughput: 1 beat/cycle.
- Output stability: while out_valid=1 and out_ready=0, out_ch, out_vm and out_sat stay constant.
- Bubbles: an empty S1 (valid=0) propagates as out_valid=0. Bubbles are not collapsed.
- Config vs data collision:
  - A cfg write and an input beat to the same channel on the same edge: the beat uses the OLD mode; the new mode applies from the next accepted beat.
  - Beats already in S1/S2 are never affected by later cfg writes.
- Channel index: in_ch and cfg_ch >= NUM_CH (non-power-of-two NUM_CH):
  - the cfg write is ignored;
  - the beat uses mode 00.
- Sign convention: POT_W-bit two's complement throughout; sgn(x) is -1 for x<0, +1 for x>0, 0 for x=0.

Optional Feature:
- Macro: LEAK_SAT_CNT_EN.
- When defined, adds port sat_cnt out 16 and input sat_cnt_clr in 1.
  - sat_cnt increments on every output handshake (out_valid && out_ready) with out_sat=1, and saturates at 16'hFFFF.
  - sat_cnt_clr synchronously zeroes it; clear wins over a simultaneous increment.
  - Reset value is 0.
- When not defined, neither port exists and no counter logic is built.

Test Plan:
- Reset, then mode 00 on ch0 with leak=-3, vm=100, out_ready=1 -> out_valid 2 cycles after accept, out_vm=97, out_sat=0, out_ch=0.
- Mode 11 on ch2 with leak=5, beats vm=-40 / 0 / 40 -> out_vm = -45 / 0 / 45.
- Saturation case:
  - Mode 01 on ch1, leak=-128 (8'h80), vm=32700 -> Le=+128, out_vm=32767, out_sat=1.
  - Mode 00, leak=-1, vm=-32768 -> out_vm=-32768, out_sat=1.
- Backpressure: stream 4 beats with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, output held stable, all 4 beats delivered in order with no loss or duplication.
- Same-edge cfg_we (ch3, mode 10) plus an input beat on ch3 with leak=7, vm=10 -> out_vm=17 (old mode 00); next ch3 beat with vm=10 -> out_vm=10.
- Assert rst_n low while 2 beats are in flight -> out_valid=0 immediately and no stale beat emitted after release; with LEAK_SAT_CNT_EN, 3 saturating handshakes -> sat_cnt=3, and pulsing sat_cnt_clr -> 0.
